// File: rtl/seq_1001_pkg.sv
// Shared definitions for the 1-0-0-1 serial sequence detector.
//   state_t    : FSM state encoding (binary, 3 bits)
//   PATTERN    : detected pattern, MSB is the earliest bit in time
//   is_detect  : decodes the detect flag from a state value
package seq_1001_pkg;

  localparam logic [3:0] PATTERN = 4'b1001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,  // no prefix matched
    S1    = 3'd1,  // "1" matched
    S10   = 3'd2,  // "10" matched
    S100  = 3'd3,  // "100" matched
    S1001 = 3'd4   // full match
  } state_t;

  // Moore output decode: only the full-match state raises the flag.
  function automatic logic is_detect(input state_t s);
    return (s == S1001);
  endfunction

endpackage

// File: rtl/seq_1001_moore.sv
// Moore-style detector for the serial pattern 1-0-0-1 with overlap.
// Ports:
//   clk   : rising-edge clock, one input bit sampled per edge
//   reset : synchronous active-high reset, returns the FSM to IDLE
//   in    : serial data bit
//   out   : detect flag, high for the one cycle the FSM sits in S1001
// The flag is registered from the next-state value, so it always equals
// (state == S1001) and never depends combinationally on `in`.
module seq_1001_moore
  import seq_1001_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  // Power-up value keeps the flag low even if reset is never applied.
  state_t r_state = IDLE;
  logic   r_out   = 1'b0;
  state_t w_next;

  // State and detect-flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_out   <= is_detect(w_next);
    end
  end

  // Next-state decode; S1001 falls back to S10/S1 so the trailing 1 can
  // start the next match.
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = in ? S1    : IDLE;
      S1:      w_next = in ? S1    : S10;
      S10:     w_next = in ? S1    : S100;
      S100:    w_next = in ? S1001 : IDLE;
      S1001:   w_next = in ? S1    : S10;
      default: w_next = IDLE;
    endcase
  end

  assign out = r_out;

endmodule

// File: tb/tb_seq_1001_moore.sv
// Self-checking bench for seq_1001_moore: directed vectors with
// hand-computed expected pulses, then random bursts against a 4-bit
// shift-register reference.
module tb_seq_1001_moore;
  import seq_1001_pkg::*;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic in_bit = 1'b0;
  logic out_bit;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_1001_moore dut (
    .clk   (clk),
    .reset (reset),
    .in    (in_bit),
    .out   (out_bit)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: out=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive on the falling edge, check 1 time unit after the rising edge.
  task automatic step(input logic r, input logic b, input logic exp, input string tag);
    @(negedge clk);
    reset  = r;
    in_bit = b;
    @(posedge clk);
    #1;
    check_bit(tag, out_bit, exp);
  endtask

  // Apply n bits (bits[n-1] first) with reset low; exp holds the expected
  // flag after each edge in the same order.
  task automatic run_vec(input string tag, input logic [15:0] bits,
                         input logic [15:0] exp, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, bits[i], exp[i], $sformatf("%s[%0d]", tag, n - 1 - i));
    end
  endtask

  logic [3:0] pat;
  logic [3:0] hist;
  int         seen;
  logic       rb;
  int         len;
  int         hold;

  initial begin
    pat = PATTERN;

    // Power-up value before any reset or clock edge.
    #1;
    check_bit("powerup", out_bit, 1'b0);

    // Basic single match, then zeros drain back to IDLE.
    step(1'b1, 1'b0, 1'b0, "rst_a");
    run_vec("single", 16'b1001000, 16'b0001000, 7);
    // IDLE check: 0,0,1,0,0,1 would give a pulse only if starting in IDLE -> after 1001
    run_vec("idle_after", 16'b001, 16'b000, 3);

    // Overlap: two pulses three cycles apart.
    step(1'b1, 1'b0, 1'b0, "rst_b");
    run_vec("overlap", 16'b1001001, 16'b0001001, 7);

    // Near misses.
    step(1'b1, 1'b0, 1'b0, "rst_c");
    run_vec("near1", 16'b1101010001, 16'b0000000000, 10);
    step(1'b1, 1'b0, 1'b0, "rst_d");
    run_vec("near2", 16'b10001, 16'b00000, 5);

    // Reset mid-sequence with in=1 (would otherwise complete the match).
    step(1'b1, 1'b0, 1'b0, "rst_e");
    run_vec("mid_pre", 16'b100, 16'b000, 3);
    step(1'b1, 1'b1, 1'b0, "mid_rst");
    // From IDLE: 0,0,1 lands in S1 without a pulse.
    run_vec("mid_post", 16'b001, 16'b000, 3);

    // Reset while in S1001; in=1 during reset, so a missed reset would
    // leave S1 and the following 0,0,1 would pulse.
    step(1'b1, 1'b0, 1'b0, "rst_f");
    run_vec("s1001_pre", 16'b1001, 16'b0001, 4);
    step(1'b1, 1'b1, 1'b0, "s1001_rst");
    run_vec("s1001_post", 16'b001, 16'b000, 3);

    // Random bursts with bit holds against a shift-register reference.
    step(1'b1, 1'b0, 1'b0, "rst_rand");
    hist = 4'b0000;
    seen = 0;
    for (int burst = 0; burst < 20; burst++) begin
      len = $urandom_range(4, 10);
      for (int k = 0; k < len; k++) begin
        rb   = 1'($urandom_range(0, 1));
        hold = $urandom_range(0, 3);
        for (int h = 0; h <= hold; h++) begin
          hist = {hist[2:0], rb};
          seen++;
          step(1'b0, rb, (seen >= 4) && (hist == pat),
               $sformatf("rand_b%0d", burst));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
